// File: rtl/decode_stage.sv
// RV32I decode stage: register file with writeback bypass, instruction decode,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_pc,
  input  logic [31:0] instr,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        wb_enable,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [4:0]  out_pc,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] imm,
  output logic        alu_src,
  output logic [4:0]  alu_op,
  output logic [3:0]  jump_type,
  output logic        reg_wrenable,
  output logic [4:0]  write_reg,
  output logic        mem_wrenable,
  output logic        mem_to_reg,
  output logic        ex_valid,
  output logic        stall
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  alu_op;
    logic [3:0]  jump_type;
    logic        reg_wrenable;
    logic [4:0]  write_reg;
    logic        mem_wrenable;
    logic        mem_to_reg;
    logic        ex_valid;
  } idex_t;

  idex_t       idex_q, idex_d, dec;
  logic [31:0] rf_q [0:31];
  logic [31:0] rf_d [0:31];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_u, imm_b, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        valid_op, uses_rs1, uses_rs2, reg_we, load_use;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  // Branch and jump offsets are carried in word units since the PC is a word address.
  assign imm_b = $signed({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}) >>> 2;
  assign imm_j = $signed({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}) >>> 2;

  // Writeback in the same cycle is forwarded so the read never sees stale data.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (wb_enable && wb_reg == rs1) ? wb_data : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (wb_enable && wb_reg == rs2) ? wb_data : rf_q[rs2];

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    dec      = '0;
    valid_op = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    reg_we   = 1'b0;
    case (opcode)
      OPC_OP: begin
        valid_op   = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        reg_we     = 1'b1;
        dec.alu_op = {1'b0, instr[30], funct3};
      end
      OPC_OP_IMM: begin
        valid_op    = 1'b1;
        uses_rs1    = 1'b1;
        reg_we      = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_i;
        dec.alu_op  = {1'b0, (funct3 == 3'b101) & instr[30], funct3};
      end
      OPC_LOAD: begin
        valid_op       = 1'b1;
        uses_rs1       = 1'b1;
        reg_we         = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm        = imm_i;
        dec.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        valid_op         = 1'b1;
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        dec.alu_src      = 1'b1;
        dec.imm          = imm_s;
        dec.mem_wrenable = 1'b1;
      end
      OPC_BRANCH: begin
        valid_op   = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec.imm    = imm_b;
        dec.alu_op = 5'b01000;
        case (funct3)
          3'b000:  dec.jump_type = 4'b0100;
          3'b001:  dec.jump_type = 4'b0101;
          3'b100:  dec.jump_type = 4'b1000;
          3'b101:  dec.jump_type = 4'b1001;
          3'b110:  dec.jump_type = 4'b1100;
          3'b111:  dec.jump_type = 4'b1101;
          default: valid_op = 1'b0;
        endcase
      end
      OPC_JAL: begin
        valid_op      = 1'b1;
        reg_we        = 1'b1;
        dec.imm       = imm_j;
        dec.jump_type = 4'b0010;
      end
      OPC_JALR: begin
        valid_op      = 1'b1;
        uses_rs1      = 1'b1;
        reg_we        = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
        dec.jump_type = 4'b0011;
      end
      OPC_LUI: begin
        valid_op    = 1'b1;
        reg_we      = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_u;
        dec.alu_op  = 5'b10000;
      end
      default: valid_op = 1'b0;
    endcase
    dec.reg_wrenable = reg_we && (rd != 5'd0);
    dec.write_reg    = rd;
    dec.pc           = in_pc;
    dec.rd1          = rs1_val;
    dec.rd2          = rs2_val;
    dec.ex_valid     = 1'b1;
  end

  always_comb begin
    load_use = if_valid && valid_op && idex_q.ex_valid && idex_q.mem_to_reg &&
               (idex_q.write_reg != 5'd0) &&
               ((uses_rs1 && rs1 == idex_q.write_reg) || (uses_rs2 && rs2 == idex_q.write_reg));
    stall    = load_use && !flush;
    idex_d   = (if_valid && valid_op && !flush && !load_use) ? dec : '0;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_enable && wb_reg != 5'd0) rf_d[wb_reg] = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
      // NOTE: the register file must come out of reset all-zero, so every entry is cleared here.
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      idex_q <= idex_d;
      rf_q   <= rf_d;
    end
  end

  assign out_pc       = idex_q.pc;
  assign rd1          = idex_q.rd1;
  assign rd2          = idex_q.rd2;
  assign imm          = idex_q.imm;
  assign alu_src      = idex_q.alu_src;
  assign alu_op       = idex_q.alu_op;
  assign jump_type    = idex_q.jump_type;
  assign reg_wrenable = idex_q.reg_wrenable;
  assign write_reg    = idex_q.write_reg;
  assign mem_wrenable = idex_q.mem_wrenable;
  assign mem_to_reg   = idex_q.mem_to_reg;
  assign ex_valid     = idex_q.ex_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations checked with
// immediate assertions after each step.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  in_pc;
  logic [31:0] instr;
  logic        if_valid, flush, wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  out_pc;
  logic [31:0] rd1, rd2, imm;
  logic        alu_src;
  logic [4:0]  alu_op;
  logic [3:0]  jump_type;
  logic        reg_wrenable;
  logic [4:0]  write_reg;
  logic        mem_wrenable, mem_to_reg, ex_valid, stall;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_pc(in_pc), .instr(instr), .if_valid(if_valid),
    .flush(flush), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_pc(out_pc), .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .jump_type(jump_type), .reg_wrenable(reg_wrenable),
    .write_reg(write_reg), .mem_wrenable(mem_wrenable), .mem_to_reg(mem_to_reg),
    .ex_valid(ex_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_LW     = 32'h0000A103; // lw x2,0(x1)
  localparam logic [31:0] I_ADD3   = 32'h002101B3; // add x3,x2,x2
  localparam logic [31:0] I_ADD65  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] I_ADD75  = 32'h000283B3; // add x7,x5,x0
  localparam logic [31:0] I_ADD600 = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] I_JAL    = 32'h008000EF; // jal x1,+8
  localparam logic [31:0] I_BNE    = 32'hFE001EE3; // bne x0,x0,-4
  localparam logic [31:0] I_LUI    = 32'h12345237; // lui x4,0x12345
  localparam logic [31:0] I_SRAI   = 32'h4030D093; // srai x1,x1,3
  localparam logic [31:0] I_AUIPC  = 32'h00000097; // auipc x1,0

  initial begin
    rst = 1'b1; in_pc = '0; instr = '0; if_valid = 1'b0; flush = 1'b0;
    wb_enable = 1'b0; wb_reg = '0; wb_data = '0;
    #3;
    check("rst ex_valid", 32'(ex_valid), 32'd0);
    check("rst imm", imm, 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    #9;
    rst = 1'b0;

    // addi x1,x0,5 at pc 3
    instr = I_ADDI; in_pc = 5'd3; if_valid = 1'b1;
    tick();
    check("addi ex_valid", 32'(ex_valid), 32'd1);
    check("addi alu_op", 32'(alu_op), 32'd0);
    check("addi alu_src", 32'(alu_src), 32'd1);
    check("addi imm", imm, 32'd5);
    check("addi rd1", rd1, 32'd0);
    check("addi reg_wrenable", 32'(reg_wrenable), 32'd1);
    check("addi write_reg", 32'(write_reg), 32'd1);
    check("addi out_pc", 32'(out_pc), 32'd3);

    // lw followed by dependent add: one-cycle stall and bubble
    instr = I_LW; in_pc = 5'd4;
    #1 check("lw stall", 32'(stall), 32'd0);
    tick();
    check("lw mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("lw write_reg", 32'(write_reg), 32'd2);
    instr = I_ADD3; in_pc = 5'd5;
    #1 check("loaduse stall", 32'(stall), 32'd1);
    tick();
    check("loaduse bubble ex_valid", 32'(ex_valid), 32'd0);
    check("loaduse bubble reg_we", 32'(reg_wrenable), 32'd0);
    check("loaduse bubble mem_to_reg", 32'(mem_to_reg), 32'd0);
    check("loaduse stall released", 32'(stall), 32'd0);
    tick();
    check("add ex_valid", 32'(ex_valid), 32'd1);
    check("add alu_op", 32'(alu_op), 32'd0);
    check("add write_reg", 32'(write_reg), 32'd3);
    check("add out_pc", 32'(out_pc), 32'd5);

    // writeback bypass and later read of x5
    instr = I_ADD65; wb_enable = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    check("bypass rd1", rd1, 32'hDEADBEEF);
    check("bypass write_reg", 32'(write_reg), 32'd6);
    wb_enable = 1'b0; wb_data = '0; instr = I_ADD75;
    tick();
    check("x5 readback", rd1, 32'hDEADBEEF);
    check("x5 rd2 is x0", rd2, 32'd0);

    // jal x1,+8
    instr = I_JAL;
    tick();
    check("jal jump_type", 32'(jump_type), 32'b0010);
    check("jal imm", imm, 32'd2);
    check("jal reg_wrenable", 32'(reg_wrenable), 32'd1);
    check("jal write_reg", 32'(write_reg), 32'd1);
    check("jal alu_src", 32'(alu_src), 32'd0);

    // bne with negative offset
    instr = I_BNE;
    tick();
    check("bne jump_type", 32'(jump_type), 32'b0101);
    check("bne alu_op", 32'(alu_op), 32'b01000);
    check("bne imm", imm, 32'hFFFFFFFF);
    check("bne reg_wrenable", 32'(reg_wrenable), 32'd0);

    // lui and srai
    instr = I_LUI;
    tick();
    check("lui imm", imm, 32'h12345000);
    check("lui alu_op", 32'(alu_op), 32'b10000);
    check("lui write_reg", 32'(write_reg), 32'd4);
    instr = I_SRAI;
    tick();
    check("srai alu_op", 32'(alu_op), 32'b01101);
    check("srai imm", imm, 32'h00000403);

    // unsupported opcode becomes a bubble
    instr = I_AUIPC;
    tick();
    check("auipc ex_valid", 32'(ex_valid), 32'd0);
    check("auipc reg_wrenable", 32'(reg_wrenable), 32'd0);

    // if_valid low gives a bubble
    instr = I_ADDI; if_valid = 1'b0;
    tick();
    check("invalid ex_valid", 32'(ex_valid), 32'd0);
    if_valid = 1'b1;

    // writes to x0 are neither bypassed nor stored
    instr = I_ADD600; wb_enable = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFFFFFF;
    tick();
    check("x0 bypass rd1", rd1, 32'd0);
    wb_enable = 1'b0;
    tick();
    check("x0 readback rd1", rd1, 32'd0);

    // flush beats load-use stall
    instr = I_LW;
    tick();
    instr = I_ADD3; flush = 1'b1;
    #1 check("flush stall", 32'(stall), 32'd0);
    tick();
    check("flush ex_valid", 32'(ex_valid), 32'd0);
    check("flush reg_wrenable", 32'(reg_wrenable), 32'd0);
    flush = 1'b0;

    // reset pulse during a stall cycle
    instr = I_LW;
    tick();
    instr = I_ADD3;
    #1 check("pre-rst stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst stall", 32'(stall), 32'd0);
    check("rst ex_valid mid", 32'(ex_valid), 32'd0);
    check("rst mem_to_reg mid", 32'(mem_to_reg), 32'd0);
    check("rst write_reg mid", 32'(write_reg), 32'd0);
    check("rst out_pc mid", 32'(out_pc), 32'd0);
    instr = I_ADD75;
    #1 rst = 1'b0;
    tick();
    check("post-rst ex_valid", 32'(ex_valid), 32'd1);
    check("post-rst x5", rd1, 32'd0);
    check("post-rst write_reg", 32'(write_reg), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
